// File: rtl/classify_feeder.sv
// Streams centroid words then data points from a RAM into the classify pipe.
// Optional FEEDER_STALL_EN adds a pipe_ready input that throttles point reads.
module classify_feeder #(
    parameter int addrWidth    = 8,
    parameter int dataWidth    = 91,
    parameter int centroid_num = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [addrWidth-1:0]    num_points,
`ifdef FEEDER_STALL_EN
    input  logic                    pipe_ready,
`endif
    output logic                    ram_rd_en,
    output logic [addrWidth-1:0]    ram_addr,
    input  logic [dataWidth-1:0]    ram_rdata,
    output logic [centroid_num-1:0] centroid_en,
    output logic [dataWidth-1:0]    centroid_data,
    output logic [dataWidth-1:0]    data_to_pipe,
    output logic                    input_reg_en,
    output logic [addrWidth-1:0]    point_index,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, LOAD_C, STREAM, FIN} state_t;

    localparam logic [addrWidth-1:0] C_NUM   = addrWidth'(centroid_num);
    localparam logic [addrWidth-1:0] LAST_C  = addrWidth'(centroid_num - 1);
    localparam logic [addrWidth-1:0] MAX_PTS = addrWidth'((1 << addrWidth) - centroid_num);

    state_t                  state, state_n;
    logic [addrWidth-1:0]    rem, rem_n;
    logic                    rd_n, busy_n, done_n, ire_n, ready;
    logic [addrWidth-1:0]    addr_n, pidx_n;
    logic [centroid_num-1:0] cen_n;

    assign centroid_data = ram_rdata;
    assign data_to_pipe  = ram_rdata;

`ifdef FEEDER_STALL_EN
    assign ready = pipe_ready;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // rem counts point reads not yet issued; ram_addr holds the last issued address.
    always_comb begin
        state_n = state;
        rd_n    = 1'b0;
        addr_n  = ram_addr;
        rem_n   = rem;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    state_n = LOAD_C;
                    rd_n    = 1'b1;
                    addr_n  = '0;
                    rem_n   = (num_points > MAX_PTS) ? MAX_PTS : num_points;
                    busy_n  = 1'b1;
                end
            end
            LOAD_C: begin
                if (ram_addr == LAST_C) begin
                    if (rem == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = STREAM;
                        if (ready) begin
                            rd_n   = 1'b1;
                            addr_n = ram_addr + 1'b1;
                            rem_n  = rem - 1'b1;
                        end
                    end
                end else begin
                    rd_n   = 1'b1;
                    addr_n = ram_addr + 1'b1;
                end
            end
            STREAM: begin
                if (rem == '0) begin
                    state_n = FIN;
                end else if (ready) begin
                    rd_n   = 1'b1;
                    addr_n = ram_addr + 1'b1;
                    rem_n  = rem - 1'b1;
                end
            end
            FIN: begin
                state_n = IDLE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes follow the read that produced the data by one cycle, so the
    // address alone decides whether the returning word is a centroid or a point.
    always_comb begin
        cen_n = '0;
        for (int k = 0; k < centroid_num; k++)
            cen_n[k] = ram_rd_en && (ram_addr == addrWidth'(k));
        ire_n  = ram_rd_en && (ram_addr >= C_NUM);
        pidx_n = ire_n ? (ram_addr - C_NUM) : point_index;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_en    <= 1'b0;
            ram_addr     <= '0;
            rem          <= '0;
            centroid_en  <= '0;
            input_reg_en <= 1'b0;
            point_index  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ram_rd_en    <= rd_n;
            ram_addr     <= addr_n;
            rem          <= rem_n;
            centroid_en  <= cen_n;
            input_reg_en <= ire_n;
            point_index  <= pidx_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_classify_feeder.sv
// Scoreboard bench for classify_feeder; RAM model returns word k = k.
// Stall scenario is compiled in only when FEEDER_STALL_EN is defined.
module tb_classify_feeder;

    localparam int AW = 8;
    localparam int DW = 91;
    localparam int CN = 8;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [AW-1:0] num_points;
    logic          pipe_ready;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [CN-1:0] centroid_en;
    logic [DW-1:0] centroid_data, data_to_pipe;
    logic          input_reg_en;
    logic [AW-1:0] point_index;
    logic          busy, done;

    classify_feeder #(.addrWidth(AW), .dataWidth(DW), .centroid_num(CN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_points(num_points),
`ifdef FEEDER_STALL_EN
        .pipe_ready(pipe_ready),
`endif
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .centroid_en(centroid_en), .centroid_data(centroid_data),
        .data_to_pipe(data_to_pipe), .input_reg_en(input_reg_en),
        .point_index(point_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) ram_rdata <= DW'(ram_addr);

    typedef struct {
        int kind;   // 0 centroid, 1 point, 2 done
        int cyc;
        int data;
        int idx;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   edge_cnt = 0;
    int   t0 = 1 << 30;
    int   max_addr = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rel();
        return edge_cnt - t0 + 1;
    endfunction

    // Monitor: every strobe or done pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int   obs;
        if (rst_n && ram_rd_en && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        if (rst_n && centroid_en != '0 && input_reg_en) chk("excl", 128'(1), 128'(0));
        if (rst_n && (centroid_en != '0 || input_reg_en || done)) begin
            if (q.size() == 0) begin
                chk("unexpected", 128'(1), 128'(0));
            end else begin
                e   = q.pop_front();
                obs = done ? 2 : (input_reg_en ? 1 : 0);
                chk("kind", 128'(obs), 128'(e.kind));
                chk("cyc", 128'(rel()), 128'(e.cyc));
                if (e.kind == 0) begin
                    chk("cen", 128'(centroid_en), 128'(1) << e.idx);
                    chk("cdat", 128'(centroid_data), 128'(e.data));
                    chk("busy", 128'(busy), 128'(1));
                end else if (e.kind == 1) begin
                    chk("pdat", 128'(data_to_pipe), 128'(e.data));
                    chk("pidx", 128'(point_index), 128'(e.idx));
                end else begin
                    chk("busy_done", 128'(busy), 128'(0));
                end
            end
        end
    end

    task automatic run(input int n, input bit stall);
        int   np, c;
        exp_t e;
        np = (n > 256 - CN) ? 256 - CN : n;
        for (int k = 0; k < CN; k++) begin
            e = '{kind: 0, cyc: k + 2, data: k, idx: k};
            q.push_back(e);
        end
        // Next point read is committed at edge c (needs pipe ready in cycle c).
        c = CN;
        for (int i = 0; i < np; i++) begin
            while (stall && c >= 10 && c <= 12) c++;
            e = '{kind: 1, cyc: c + 2, data: CN + i, idx: i};
            q.push_back(e);
            c++;
        end
        e = '{kind: 2, cyc: c + 2, data: 0, idx: 0};
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        num_points = AW'(n);
        @(posedge clk); #1;
        t0 = edge_cnt;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("timeout", 128'(q.size()), 128'(0));
            q.delete();
        end
    endtask

    task automatic wait_rel(input int c);
        int n = 0;
        while (rel() != c && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd"},   128'(ram_rd_en),    128'(0));
        chk({tag, "_addr"}, 128'(ram_addr),     128'(0));
        chk({tag, "_cen"},  128'(centroid_en),  128'(0));
        chk({tag, "_ire"},  128'(input_reg_en), 128'(0));
        chk({tag, "_pidx"}, 128'(point_index),  128'(0));
        chk({tag, "_busy"}, 128'(busy),         128'(0));
        chk({tag, "_done"}, 128'(done),         128'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_points = '0; pipe_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero("rst");
        @(negedge clk) rst_n = 1'b1;

        run(4, 1'b0);
        wait_idle(60);

        run(0, 1'b0);
        wait_idle(60);

        // Stray start mid-run must not restart or add a second done.
        run(4, 1'b0);
        wait_rel(5);
        #2 start = 1'b1; num_points = 8'd2;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(60);
        repeat (5) @(negedge clk);

        // Abort mid-run; nothing further may appear from that run.
        run(4, 1'b0);
        wait_rel(11);
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        repeat (3) @(negedge clk);
        q.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(4, 1'b0);
        wait_idle(60);

        run(3, 1'b0);
        wait_idle(60);

        max_addr = 0;
        run(255, 1'b0);
        wait_idle(400);
        chk("last_addr", 128'(max_addr), 128'(255));

`ifdef FEEDER_STALL_EN
        run(4, 1'b1);
        while (rel() < 13) begin
            @(negedge clk);
            #2 pipe_ready = !(rel() >= 10 && rel() <= 12);
        end
        pipe_ready = 1'b1;
        wait_idle(60);
`endif

        repeat (5) @(negedge clk);
        chk("q_empty", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/classify_feeder.md
CLASSIFY_FEEDER -- requirements
Module: classify_feeder

Interface
REQ-001 The parameter addrWidth SHALL default to 8 and set the RAM address width.
REQ-002 The parameter dataWidth SHALL default to 91 and set the RAM word, centroid and data point width.
REQ-003 The parameter centroid_num SHALL default to 8 and set the number of centroid words.
REQ-004 The port clk SHALL be an input of width 1 and is the single clock; all state changes on its rising edge.
REQ-005 The port rst_n SHALL be an input of width 1 and is the reset, asynchronous and active-low.
REQ-006 The port start SHALL be an input of width 1: a one-cycle request to begin a load-and-stream run.
REQ-007 The port num_points SHALL be an input of width addrWidth: the number of data points to stream, sampled with start.
REQ-008 The port ram_rd_en SHALL be an output of width 1: the RAM read strobe.
REQ-009 The port ram_addr SHALL be an output of width addrWidth: the RAM read address.
REQ-010 The port ram_rdata SHALL be an input of width dataWidth: RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-011 The port centroid_en SHALL be an output of width centroid_num: a one-hot centroid register load strobe.
REQ-012 The port centroid_data SHALL be an output of width dataWidth: the centroid word, a combinational copy of ram_rdata.
REQ-013 The port data_to_pipe SHALL be an output of width dataWidth: the point word, a combinational copy of ram_rdata.
REQ-014 The port input_reg_en SHALL be an output of width 1: the strobe that makes the distance stage capture data_to_pipe.
REQ-015 The port point_index SHALL be an output of width addrWidth: the index (0-based) of the point qualified by input_reg_en.
REQ-016 The port busy SHALL be an output of width 1: high from the cycle after start is accepted until done.
REQ-017 The port done SHALL be an output of width 1: a one-cycle pulse marking the end of a run.

Function
REQ-018 RAM map SHALL be: centroids at addresses 0..centroid_num-1, then point i at address centroid_num+i.
REQ-019 The FSM SHALL have the states IDLE, LOAD_C, STREAM and FIN; IDLE->LOAD_C when start=1; LOAD_C->STREAM after centroid_num reads; STREAM->FIN after the last point's input_reg_en; FIN->IDLE after 1 cycle.
REQ-020 All outputs except centroid_data and data_to_pipe SHALL be registered.
REQ-021 Timing SHALL be as follows, with start seen at edge 0: reads of addr 0..7 occur on cycles 1..8, and centroid_en[k] is high alone on cycle k+2.
REQ-022 In STREAM, the read of addr 8+i SHALL be issued and input_reg_en with point_index=i SHALL be asserted exactly 1 cycle later.
REQ-023 With no stalls, reads SHALL be back-to-back, the last input_reg_en SHALL fall on cycle 9+N, and done SHALL be high on cycle 10+N.
REQ-024 If num_points=0, LOAD_C SHALL go directly to FIN after the last centroid_en, with no input_reg_en asserted.
REQ-025 If num_points exceeds 2^addrWidth-centroid_num, the count SHALL be clamped to 2^addrWidth-centroid_num (248 by default); ram_addr never wraps.
REQ-026 start SHALL be ignored while busy=1 or done=1, and start in IDLE on the cycle after done SHALL be accepted.
REQ-027 centroid_en and input_reg_en SHALL never be asserted in the same cycle, and ram_rd_en SHALL be 0 in IDLE and FIN.

Reset
REQ-028 While rst_n=0, the state SHALL be IDLE and ram_rd_en, ram_addr, centroid_en, input_reg_en, point_index, busy and done SHALL all be 0, independent of clk.
REQ-029 Reset asserted mid-run SHALL abort the run: no strobe after reset, and no done for the aborted run.

Configuration
REQ-030 The macro FEEDER_STALL_EN SHALL control back-pressure as follows.
- Defined: an input port pipe_ready (width 1) exists. In STREAM, a new read is issued only in cycles where pipe_ready=1. A read already issued always produces its input_reg_en, whatever pipe_ready is. Order and indices are preserved.
- Undefined: no pipe_ready port, and the block streams unconditionally as REQ-023.

Verification
REQ-031 Reset, then start with num_points=4 and RAM word k=k: centroid_en 0x01..0x80 appear on cycles 2..9 with data 0..7; input_reg_en appears on cycles 10..13 with data 8..11 and index 0..3; done appears on cycle 14.
REQ-032 start with num_points=0: eight centroid_en pulses occur, no input_reg_en occurs, and done occurs on cycle 10.
REQ-033 start with num_points=255: the run is clamped to 248 points, the last ram_addr is 255, and the last point_index is 247.
REQ-034 start pulsed on cycle 5 of a run: it is ignored, and the run completes unchanged with exactly one done.
REQ-035 rst_n driven to 0 on cycle 11 of an N=4 run: all outputs go to 0 immediately and no done occurs; a new start after release gives the full REQ-031 sequence.
REQ-036 With FEEDER_STALL_EN defined and pipe_ready=0 on cycles 10..12 (N=4): 4 input_reg_en occur with indices 0..3 in order, the read gap matches the stall, and done follows the last strobe by 1 cycle.
